// File: rtl/exec_stage_if.sv
// Bundle of the execute-stage inputs from decode and the registered results
// handed to the memory stage; master is the upstream/driver side.
interface exec_stage_if;
    logic        regDst_i;
    logic        aluSrc_i;
    logic [1:0]  aluOp_i;
    logic        branch_i;
    logic        memToRead_i;
    logic        memToWrite_i;
    logic        memToReg_i;
    logic        regWrite_i;
    logic [31:0] nextInstrAddr_i;
    logic [31:0] rsData_i;
    logic [31:0] rtData_i;
    logic [31:0] signExtend_i;
    logic [4:0]  rtAddr_i;
    logic [4:0]  rdAddr_i;
    logic [5:0]  funct_i;
    logic        flush_i;
    logic        stall_o;
    logic        branchTaken_o;
    logic [31:0] branchTarget_o;
    logic [31:0] aluResult_o;
    logic [31:0] rtData_o;
    logic [4:0]  writeAddr_o;
    logic        memToRead_o;
    logic        memToWrite_o;
    logic        memToReg_o;
    logic        regWrite_o;

    modport master (
        output regDst_i, aluSrc_i, aluOp_i, branch_i, memToRead_i, memToWrite_i,
               memToReg_i, regWrite_i, nextInstrAddr_i, rsData_i, rtData_i,
               signExtend_i, rtAddr_i, rdAddr_i, funct_i, flush_i,
        input  stall_o, branchTaken_o, branchTarget_o, aluResult_o, rtData_o,
               writeAddr_o, memToRead_o, memToWrite_o, memToReg_o, regWrite_o
    );

    modport slave (
        input  regDst_i, aluSrc_i, aluOp_i, branch_i, memToRead_i, memToWrite_i,
               memToReg_i, regWrite_i, nextInstrAddr_i, rsData_i, rtData_i,
               signExtend_i, rtAddr_i, rdAddr_i, funct_i, flush_i,
        output stall_o, branchTaken_o, branchTarget_o, aluResult_o, rtData_o,
               writeAddr_o, memToRead_o, memToWrite_o, memToReg_o, regWrite_o
    );
endinterface

// File: rtl/exec_stage.sv
// Execute stage: ALU, beq resolution, and an iterative 32-cycle mult/div unit
// feeding HI/LO; results land in a pipeline register toward the memory stage.
module exec_stage (
    input  logic clk_i,
    input  logic rst_n_i,
    exec_stage_if.slave bus
);
    // state | meaning
    // IDLE  | no mult/div in flight; a mult/div funct launches
    // BUSY  | one shift-add / restoring-divide iteration per cycle
    // DONE  | HI/LO written; held instruction leaves as a bubble
    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

    localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] work_q, work_d;
    logic [31:0] mc_q, mc_d, a_raw_q, a_raw_d, b_raw_q, b_raw_d;
    logic        is_div_q, is_div_d, is_signed_q, is_signed_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic [31:0] alu_q, alu_d, tgt_q, tgt_d, rtd_q, rtd_d;
    logic [4:0]  wa_q, wa_d;
    logic        bt_q, bt_d, mr_q, mr_d, mw_q, mw_d, m2r_q, m2r_d, rw_q, rw_d;

    logic [31:0] op_b, alu_res, br_diff, rs_mag, rt_mag;
    logic [4:0]  shamt;
    logic        is_muldiv, launch_signed, stall, bubble;
    logic [32:0] mul_sum, div_shift, div_trial;
    logic [63:0] step, prod;
    logic        a_neg, b_neg;

    always_comb begin
        op_b    = bus.aluSrc_i ? bus.signExtend_i : bus.rtData_i;
        shamt   = bus.signExtend_i[10:6];
        alu_res = '0;
        unique case (bus.aluOp_i)
            2'b00: alu_res = bus.rsData_i + op_b;
            2'b01: alu_res = bus.rsData_i - op_b;
            2'b11: alu_res = bus.rsData_i | op_b;
            2'b10: begin
                case (bus.funct_i)
                    6'h20, 6'h21: alu_res = bus.rsData_i + op_b;
                    6'h22, 6'h23: alu_res = bus.rsData_i - op_b;
                    6'h24: alu_res = bus.rsData_i & op_b;
                    6'h25: alu_res = bus.rsData_i | op_b;
                    6'h26: alu_res = bus.rsData_i ^ op_b;
                    6'h27: alu_res = ~(bus.rsData_i | op_b);
                    6'h2A: alu_res = {31'd0, $signed(bus.rsData_i) < $signed(op_b)};
                    6'h2B: alu_res = {31'd0, bus.rsData_i < op_b};
                    6'h00: alu_res = bus.rtData_i << shamt;
                    6'h02: alu_res = bus.rtData_i >> shamt;
                    6'h03: alu_res = $signed(bus.rtData_i) >>> shamt;
                    6'h10: alu_res = hi_q;
                    6'h12: alu_res = lo_q;
                    default: alu_res = '0;
                endcase
            end
        endcase
        br_diff = bus.rsData_i - op_b;
    end

    // Unsigned iteration cores; operand signs are reapplied when the last step lands.
    always_comb begin
        mul_sum   = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, mc_q} : 33'd0);
        div_shift = {work_q[63:32], work_q[31]};
        div_trial = div_shift - {1'b0, mc_q};
        step      = is_div_q
                  ? {div_trial[32] ? div_shift[31:0] : div_trial[31:0], work_q[30:0], ~div_trial[32]}
                  : {mul_sum, work_q[31:1]};
        a_neg     = is_signed_q & a_raw_q[31];
        b_neg     = is_signed_q & b_raw_q[31];
        prod      = (a_neg ^ b_neg) ? -step : step;
    end

    always_comb begin
        is_muldiv     = (bus.aluOp_i == 2'b10) &&
                        (bus.funct_i inside {F_MULT, F_MULTU, F_DIV, F_DIVU});
        launch_signed = (bus.funct_i == F_MULT) || (bus.funct_i == F_DIV);
        rs_mag        = (launch_signed && bus.rsData_i[31]) ? -bus.rsData_i : bus.rsData_i;
        rt_mag        = (launch_signed && bus.rtData_i[31]) ? -bus.rtData_i : bus.rtData_i;

        state_d     = state_q;
        cnt_d       = cnt_q;
        work_d      = work_q;
        mc_d        = mc_q;
        a_raw_d     = a_raw_q;
        b_raw_d     = b_raw_q;
        is_div_d    = is_div_q;
        is_signed_d = is_signed_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        stall       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (is_muldiv && !bus.flush_i) begin
                    stall       = 1'b1;
                    state_d     = ST_BUSY;
                    cnt_d       = '0;
                    is_div_d    = bus.funct_i[1];
                    is_signed_d = launch_signed;
                    a_raw_d     = bus.rsData_i;
                    b_raw_d     = bus.rtData_i;
                    mc_d        = bus.funct_i[1] ? rt_mag : rs_mag;
                    work_d      = {32'd0, bus.funct_i[1] ? rs_mag : rt_mag};
                end
            end
            ST_BUSY: begin
                stall = 1'b1;
                if (bus.flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    work_d = step;
                    cnt_d  = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = ST_DONE;
                        if (!is_div_q) begin
                            hi_d = prod[63:32];
                            lo_d = prod[31:0];
                        end else if (b_raw_q == 32'd0) begin
                            hi_d = a_raw_q;
                            lo_d = 32'hFFFF_FFFF;
                        end else begin
                            lo_d = (a_neg ^ b_neg) ? -step[31:0] : step[31:0];
                            hi_d = a_neg ? -step[63:32] : step[63:32];
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // mult/div instructions never reach memory as real work
        bubble = bus.flush_i | stall | is_muldiv;
        alu_d  = bubble ? '0 : alu_res;
        tgt_d  = bubble ? '0 : bus.nextInstrAddr_i + {bus.signExtend_i[29:0], 2'b00};
        rtd_d  = bubble ? '0 : bus.rtData_i;
        wa_d   = bubble ? '0 : (bus.regDst_i ? bus.rdAddr_i : bus.rtAddr_i);
        bt_d   = !bubble && bus.branch_i && (br_diff == 32'd0);
        mr_d   = !bubble && bus.memToRead_i;
        mw_d   = !bubble && bus.memToWrite_i;
        m2r_d  = !bubble && bus.memToReg_i;
        rw_d   = !bubble && bus.regWrite_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;  cnt_q <= '0;  work_q <= '0;  mc_q <= '0;
            a_raw_q <= '0;  b_raw_q <= '0;  is_div_q <= 1'b0;  is_signed_q <= 1'b0;
            hi_q <= '0;  lo_q <= '0;
            alu_q <= '0;  tgt_q <= '0;  rtd_q <= '0;  wa_q <= '0;  bt_q <= 1'b0;
            mr_q <= 1'b0;  mw_q <= 1'b0;  m2r_q <= 1'b0;  rw_q <= 1'b0;
        end else begin
            state_q <= state_d;  cnt_q <= cnt_d;  work_q <= work_d;  mc_q <= mc_d;
            a_raw_q <= a_raw_d;  b_raw_q <= b_raw_d;  is_div_q <= is_div_d;
            is_signed_q <= is_signed_d;  hi_q <= hi_d;  lo_q <= lo_d;
            alu_q <= alu_d;  tgt_q <= tgt_d;  rtd_q <= rtd_d;  wa_q <= wa_d;  bt_q <= bt_d;
            mr_q <= mr_d;  mw_q <= mw_d;  m2r_q <= m2r_d;  rw_q <= rw_d;
        end
    end

    // stall is dropped while reset is asserted so a held mult/div cannot stall a reset cycle
    assign bus.stall_o        = stall & rst_n_i;
    assign bus.branchTaken_o  = bt_q;
    assign bus.branchTarget_o = tgt_q;
    assign bus.aluResult_o    = alu_q;
    assign bus.rtData_o       = rtd_q;
    assign bus.writeAddr_o    = wa_q;
    assign bus.memToRead_o    = mr_q;
    assign bus.memToWrite_o   = mw_q;
    assign bus.memToReg_o     = m2r_q;
    assign bus.regWrite_o     = rw_q;
endmodule

// File: tb/tb_exec_stage.sv
// Bench for exec_stage: ALU/branch vector table through a scoreboard queue,
// plus mult/div, flush and reset sequences.
module tb_exec_stage;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    exec_stage_if u_if ();
    exec_stage dut (.clk_i(clk), .rst_n_i(rst_n), .bus(u_if));

    typedef struct packed {
        logic [31:0] alu;
        logic [4:0]  wa;
        logic        bt;
        logic [31:0] btgt;
        logic [31:0] rtd;
        logic [3:0]  ctl;   // memToRead, memToWrite, memToReg, regWrite
    } out_t;

    typedef struct packed {
        logic [1:0]  op;
        logic [5:0]  fn;
        logic        rdst, asrc, br;
        logic [3:0]  ctl;
        logic [31:0] rs, rt, imm, npc;
        logic [4:0]  rta, rda;
        out_t        exp;
    } vec_t;

    out_t sb[$];
    vec_t vecs[$];

    function automatic vec_t mk(input logic [1:0] op, input logic [5:0] fn,
                                input logic rdst, input logic asrc, input logic br,
                                input logic [3:0] ctl, input logic [31:0] rs, input logic [31:0] rt,
                                input logic [31:0] imm, input logic [31:0] npc,
                                input logic [4:0] rta, input logic [4:0] rda,
                                input logic [31:0] e_alu, input logic e_bt);
        vec_t v;
        v.op = op;  v.fn = fn;  v.rdst = rdst;  v.asrc = asrc;  v.br = br;  v.ctl = ctl;
        v.rs = rs;  v.rt = rt;  v.imm = imm;  v.npc = npc;  v.rta = rta;  v.rda = rda;
        v.exp.alu  = e_alu;
        v.exp.wa   = rdst ? rda : rta;
        v.exp.bt   = e_bt;
        v.exp.btgt = npc + (imm << 2);
        v.exp.rtd  = rt;
        v.exp.ctl  = ctl;
        return v;
    endfunction

    function automatic vec_t mk_mf(input logic [5:0] fn, input logic [31:0] e);
        return mk(2'b10, fn, 1'b1, 1'b0, 1'b0, 4'b0001, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd2, e, 1'b0);
    endfunction

    function automatic out_t cur_out();
        out_t a;
        a.alu  = u_if.aluResult_o;
        a.wa   = u_if.writeAddr_o;
        a.bt   = u_if.branchTaken_o;
        a.btgt = u_if.branchTarget_o;
        a.rtd  = u_if.rtData_o;
        a.ctl  = {u_if.memToRead_o, u_if.memToWrite_o, u_if.memToReg_o, u_if.regWrite_o};
        return a;
    endfunction

    task automatic check_out(input string name, input out_t e);
        out_t a;
        a = cur_out();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got alu=%h wa=%0d bt=%b tgt=%h rtd=%h ctl=%b, expected alu=%h wa=%0d bt=%b tgt=%h rtd=%h ctl=%b",
                     name, a.alu, a.wa, a.bt, a.btgt, a.rtd, a.ctl, e.alu, e.wa, e.bt, e.btgt, e.rtd, e.ctl);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        u_if.aluOp_i = v.op;  u_if.funct_i = v.fn;  u_if.regDst_i = v.rdst;
        u_if.aluSrc_i = v.asrc;  u_if.branch_i = v.br;
        {u_if.memToRead_i, u_if.memToWrite_i, u_if.memToReg_i, u_if.regWrite_i} = v.ctl;
        u_if.rsData_i = v.rs;  u_if.rtData_i = v.rt;  u_if.signExtend_i = v.imm;
        u_if.nextInstrAddr_i = v.npc;  u_if.rtAddr_i = v.rta;  u_if.rdAddr_i = v.rda;
        u_if.flush_i = 1'b0;
    endtask

    task automatic pop_check(input string name);
        out_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got empty scoreboard expected a queued result", name);
        end else begin
            e = sb.pop_front();
            check_out(name, e);
        end
    endtask

    task automatic step_vec(input string name, input vec_t v);
        drive(v);
        sb.push_back(v.exp);
        @(negedge clk);
        pop_check(name);
    endtask

    task automatic run_muldiv(input string name, input logic [31:0] rs, input logic [31:0] rt,
                              input logic [5:0] fn);
        vec_t v;
        int   n;
        v = mk(2'b10, fn, 1'b1, 1'b0, 1'b0, 4'b0001, rs, rt, 32'd0, 32'd0, 5'd0, 5'd4, 32'd0, 1'b0);
        v.exp = '0;
        drive(v);
        #1;
        n = 0;
        while (u_if.stall_o === 1'b1 && n < 60) begin
            n++;
            @(negedge clk);
            #1;
        end
        check_int({name, "_stall_cycles"}, n, 33);
        check_out({name, "_stall_bubble"}, '0);
        sb.push_back(v.exp);
        @(negedge clk);
        pop_check({name, "_done_bubble"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        rst_n = 1'b0;
        drive(mk(2'b00, 6'h00, 1'b0, 1'b0, 1'b0, 4'b0000, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 32'd0, 1'b0));
        repeat (3) @(negedge clk);
        check_out("reset_out", '0);
        check_int("reset_stall", int'(u_if.stall_o), 0);
        rst_n = 1'b1;

        //            op     fn     rdst  asrc  br    ctl      rs            rt            imm           npc          rta    rda    alu           bt
        vecs.push_back(mk(2'b10, 6'h20, 1'b1, 1'b0, 1'b0, 4'b0001, 32'd5,        32'd7,        32'd0,        32'd0,       5'd0,  5'd3,  32'd12,       1'b0));
        vecs.push_back(mk(2'b01, 6'h00, 1'b0, 1'b0, 1'b1, 4'b0000, 32'd9,        32'd9,        32'hFFFFFFFF, 32'h100,     5'd4,  5'd0,  32'd0,        1'b1));
        vecs.push_back(mk(2'b10, 6'h22, 1'b1, 1'b0, 1'b0, 4'b0001, 32'd3,        32'd5,        32'd0,        32'd0,       5'd0,  5'd6,  32'hFFFFFFFE, 1'b0));
        vecs.push_back(mk(2'b10, 6'h24, 1'b1, 1'b0, 1'b0, 4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        32'd0,       5'd0,  5'd7,  32'hF000F000, 1'b0));
        vecs.push_back(mk(2'b10, 6'h25, 1'b1, 1'b0, 1'b0, 4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        32'd0,       5'd0,  5'd7,  32'hFFF0FFF0, 1'b0));
        vecs.push_back(mk(2'b10, 6'h26, 1'b1, 1'b0, 1'b0, 4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        32'd0,       5'd0,  5'd7,  32'h0FF00FF0, 1'b0));
        vecs.push_back(mk(2'b10, 6'h27, 1'b1, 1'b0, 1'b0, 4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        32'd0,       5'd0,  5'd7,  32'h000F000F, 1'b0));
        vecs.push_back(mk(2'b10, 6'h2A, 1'b1, 1'b0, 1'b0, 4'b0001, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,       5'd0,  5'd8,  32'd1,        1'b0));
        vecs.push_back(mk(2'b10, 6'h2B, 1'b1, 1'b0, 1'b0, 4'b0001, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,       5'd0,  5'd8,  32'd0,        1'b0));
        vecs.push_back(mk(2'b10, 6'h00, 1'b1, 1'b0, 1'b0, 4'b0001, 32'd0,        32'h80000001, 32'h100,      32'd0,       5'd0,  5'd9,  32'h00000010, 1'b0));
        vecs.push_back(mk(2'b10, 6'h02, 1'b1, 1'b0, 1'b0, 4'b0001, 32'd0,        32'h80000001, 32'h100,      32'd0,       5'd0,  5'd9,  32'h08000000, 1'b0));
        vecs.push_back(mk(2'b10, 6'h03, 1'b1, 1'b0, 1'b0, 4'b0001, 32'd0,        32'h80000001, 32'h100,      32'd0,       5'd0,  5'd9,  32'hF8000000, 1'b0));
        vecs.push_back(mk(2'b00, 6'h00, 1'b0, 1'b1, 1'b0, 4'b1011, 32'd10,       32'd0,        32'hFFFFFFFE, 32'h20,      5'd8,  5'd0,  32'd8,        1'b0));
        vecs.push_back(mk(2'b11, 6'h00, 1'b0, 1'b1, 1'b0, 4'b0001, 32'h1200,     32'd0,        32'h34,       32'd0,       5'd9,  5'd0,  32'h1234,     1'b0));
        vecs.push_back(mk(2'b10, 6'h3F, 1'b1, 1'b0, 1'b0, 4'b0001, 32'd5,        32'd7,        32'd0,        32'd0,       5'd0,  5'd10, 32'd0,        1'b0));
        vecs.push_back(mk(2'b00, 6'h00, 1'b0, 1'b1, 1'b0, 4'b0100, 32'h100,      32'hDEADBEEF, 32'd4,        32'd0,       5'd1,  5'd0,  32'h104,      1'b0));
        vecs.push_back(mk(2'b10, 6'h21, 1'b1, 1'b0, 1'b0, 4'b0001, 32'hFFFFFFFF, 32'd2,        32'd0,        32'd0,       5'd0,  5'd11, 32'd1,        1'b0));
        vecs.push_back(mk(2'b01, 6'h00, 1'b0, 1'b0, 1'b1, 4'b0000, 32'd1,        32'd2,        32'd1,        32'h40,      5'd0,  5'd0,  32'hFFFFFFFF, 1'b0));
        vecs.push_back(mk_mf(6'h10, 32'd0));
        vecs.push_back(mk_mf(6'h12, 32'd0));

        for (int i = 0; i < vecs.size(); i++) begin
            step_vec($sformatf("vec%0d", i), vecs[i]);
        end

        run_muldiv("mult", 32'hFFFFFFFE, 32'd3, 6'h18);
        step_vec("mult_hi", mk_mf(6'h10, 32'hFFFFFFFF));
        step_vec("mult_lo", mk_mf(6'h12, 32'hFFFFFFFA));
        run_muldiv("multu", 32'hFFFFFFFE, 32'd3, 6'h19);
        step_vec("multu_hi", mk_mf(6'h10, 32'd2));
        step_vec("multu_lo", mk_mf(6'h12, 32'hFFFFFFFA));
        run_muldiv("divu0", 32'd7, 32'd0, 6'h1B);
        step_vec("divu0_hi", mk_mf(6'h10, 32'd7));
        step_vec("divu0_lo", mk_mf(6'h12, 32'hFFFFFFFF));
        run_muldiv("divovf", 32'h80000000, 32'hFFFFFFFF, 6'h1A);
        step_vec("divovf_hi", mk_mf(6'h10, 32'd0));
        step_vec("divovf_lo", mk_mf(6'h12, 32'h80000000));
        run_muldiv("divneg", 32'hFFFFFFF9, 32'd2, 6'h1A);
        step_vec("divneg_hi", mk_mf(6'h10, 32'hFFFFFFFF));
        step_vec("divneg_lo", mk_mf(6'h12, 32'hFFFFFFFD));

        // flush arriving with the iteration counter at 10
        v = mk(2'b10, 6'h1A, 1'b1, 1'b0, 1'b0, 4'b0001, 32'd100, 32'd3, 32'd0, 32'd0, 5'd0, 5'd4, 32'd0, 1'b0);
        drive(v);
        #1;
        check_int("flush_launch_stall", int'(u_if.stall_o), 1);
        repeat (11) @(negedge clk);
        u_if.flush_i = 1'b1;
        sb.push_back('0);
        @(negedge clk);
        pop_check("flush_bubble");
        #1;
        check_int("flush_stall_low", int'(u_if.stall_o), 0);
        step_vec("flush_hi_kept", mk_mf(6'h10, 32'hFFFFFFFF));
        step_vec("flush_lo_kept", mk_mf(6'h12, 32'hFFFFFFFD));

        // reset arriving with the iteration counter at 5
        v = mk(2'b10, 6'h19, 1'b1, 1'b0, 1'b0, 4'b0001, 32'd7, 32'd9, 32'd0, 32'd0, 5'd0, 5'd4, 32'd0, 1'b0);
        drive(v);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        sb.push_back('0);
        @(negedge clk);
        pop_check("rst_out");
        #1;
        check_int("rst_stall", int'(u_if.stall_o), 0);
        rst_n = 1'b1;
        step_vec("rst_hi", mk_mf(6'h10, 32'd0));
        step_vec("rst_lo", mk_mf(6'h12, 32'd0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/exec_stage.md
EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-002 rst_n_i  in  1  synchronous, active-low reset, sampled on rising edge of clk_i.
REQ-003 regDst_i  in  1  1 selects rdAddr_i as destination, 0 selects rtAddr_i.
REQ-004 aluSrc_i  in  1  1 selects signExtend_i as operand B, 0 selects rtData_i.
REQ-005 aluOp_i  in  2  00 add, 01 sub, 10 decode funct_i, 11 OR.
REQ-006 branch_i  in  1  conditional branch (beq) in this slot.
REQ-007 memToRead_i  in  1  load; passed through to memory stage.
REQ-008 memToWrite_i  in  1  store; passed through.
REQ-009 memToReg_i  in  1  writeback source select; passed through.
REQ-010 regWrite_i  in  1  GPR write enable; passed through.
REQ-011 nextInstrAddr_i  in  32  PC+4 of this instruction.
REQ-012 rsData_i  in  32  operand A.
REQ-013 rtData_i  in  32  operand B source and store data.
REQ-014 signExtend_i  in  32  sign-extended immediate; bits [10:6] are shamt.
REQ-015 rtAddr_i  in  5  rt field.
REQ-016 rdAddr_i  in  5  rd field.
REQ-017 funct_i  in  6  R-type function code.
REQ-018 flush_i  in  1  kill the instruction in this stage.
REQ-019 stall_o  out  1  combinational; upstream SHALL hold all inputs stable while high.
REQ-020 branchTaken_o  out  1  registered; branch and operands equal.
REQ-021 branchTarget_o  out  32  registered; nextInstrAddr_i + (signExtend_i << 2), mod 2^32.
REQ-022 aluResult_o  out  32  registered ALU result.
REQ-023 rtData_o  out  32  registered rtData_i (store data).
REQ-024 writeAddr_o  out  5  registered destination register.
REQ-025 memToRead_o / memToWrite_o / memToReg_o / regWrite_o  out  1 each  registered pass-through controls.

Function
REQ-026 Operand B = aluSrc_i ? signExtend_i : rtData_i; add/sub wrap mod 2^32, no overflow trap.
REQ-027 aluOp 10 decode: 0x20/0x21 add; 0x22/0x23 sub; 0x24 and; 0x25 or; 0x26 xor; 0x27 nor; 0x2A signed slt; 0x2B unsigned sltu; 0x00 sll, 0x02 srl, 0x03 sra of rtData_i by shamt; 0x10 mfhi; 0x12 mflo; 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu; any other code yields result 0.
REQ-028 branchTaken = branch_i AND (rsData_i - operand B == 0).
REQ-029 Mult/div FSM states IDLE, BUSY, DONE; 5-bit iteration counter.
REQ-030 IDLE + mult/div funct with aluOp 10 and no flush_i: capture operands, stall_o=1 this cycle, go to BUSY with counter 0.
REQ-031 BUSY: one iteration per cycle (shift-add multiply / restoring divide, unsigned core, signs fixed at end); stall_o=1; after counter 31 write HI/LO, go to DONE.
REQ-032 DONE: stall_o=0, no relaunch for the held instruction, return to IDLE next edge; stall_o totals exactly 33 cycles per op.
REQ-033 Mult: {HI,LO} = 64-bit product. Div: LO = quotient truncated toward zero, HI = remainder with the dividend's sign.
REQ-034 Divide by zero: HI = dividend, LO = 0xFFFFFFFF; signed 0x80000000 / -1: LO = 0x80000000, HI = 0.
REQ-035 mult/div instruction itself enters the memory stage as a bubble; mfhi/mflo return current HI/LO.
REQ-036 While stall_o=1, the output register loads a bubble: all control outputs 0, branchTaken_o 0.
REQ-037 flush_i (priority over stall): output register loads a bubble; BUSY/DONE abort to IDLE with HI/LO unchanged; stall_o low from next cycle.

Reset
REQ-038 rst_n_i=0 at an edge: all outputs 0, HI=LO=0, FSM IDLE, counter 0; an in-flight op is discarded; reset dominates flush_i.

Verification
REQ-039 add: aluOp 10, funct 0x20, rs=5, rt=7, regDst 1, rd=3, regWrite 1 -> next cycle aluResult_o 12, writeAddr_o 3, regWrite_o 1.
REQ-040 beq: branch 1, aluOp 01, rs=rt=9, nextInstrAddr 0x100, imm 0xFFFFFFFF -> branchTaken_o 1, branchTarget_o 0xFC.
REQ-041 mult 0xFFFFFFFE x 3 -> stall_o high 33 cycles; then mfhi -> 0xFFFFFFFF, mflo -> 0xFFFFFFFA.
REQ-042 divu 7/0 -> HI 7, LO 0xFFFFFFFF; div 0x80000000/0xFFFFFFFF -> LO 0x80000000, HI 0.
REQ-043 flush_i in BUSY cycle 10 of a div -> stall_o low next cycle, HI/LO keep prior values, bubble output.
REQ-044 rst_n_i low in BUSY cycle 5 -> next cycle all outputs 0, stall_o 0, HI=LO=0.
